fadd_accum: RTL and testbench



---
 rtl/fadd_accum_if.sv | 24 ++
 rtl/fadd_accum.sv | 101 ++++++++++
 tb/tb_fadd_accum.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fadd_accum_if.sv
// Sample-in / result-out stream bundle for the block accumulator.
// master = producer/consumer side, slave = accumulator side.
interface fadd_accum_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [CNT_W-1:0] len;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, len, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, len, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fadd_accum.sv
// Block accumulator wrapped around an external 32-bit signed adder: sums len samples per block.
// Optional FADD_ACCUM_SAT_EN: saturate the running sum on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for first sample of a block; adder operand a forced to 0
// ACC   | accumulating remaining samples of the block
// DONE  | result presented on out port, held until out_ready
module fadd_accum #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    fadd_accum_if.slave  bus,
    output logic [31:0]  add_a,
    output logic [31:0]  add_b,
    input  logic [31:0]  add_sum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             ovf;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = bus.in_valid && bus.in_ready;
    assign ovf     = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
    assign len_eff = (bus.len == '0) ? CNT_W'(1) : bus.len;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= CNT_W'(1);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (len_eff == CNT_W'(1)) ? S_DONE : S_ACC;
            S_ACC:  if (accept && (cnt_inc == len_q)) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (accept) begin
            if (state_q == S_IDLE) begin
                acc_d = add_sum;
                len_d = len_eff;
                cnt_d = CNT_W'(1);
                ovf_d = 1'b0;
            end else begin
                cnt_d = cnt_inc;
                ovf_d = ovf_q | ovf;
`ifdef FADD_ACCUM_SAT_EN
                // Clamp toward the sign of the running sum before the overflow.
                if (ovf) acc_d = add_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                else     acc_d = add_sum;
`else
                acc_d = add_sum;
`endif
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q != S_DONE);
        bus.out_valid = (state_q == S_DONE);
        bus.out_data  = acc_q;
        bus.out_ovf   = ovf_q;
        add_a         = (state_q == S_IDLE) ? 32'h0 : acc_q;
        add_b         = bus.in_data;
    end

endmodule

// File: tb/tb_fadd_accum.sv
// Directed bench for fadd_accum with a behavioural adder closing the add_a/add_b/add_sum loop.
module tb_fadd_accum;

    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] add_a, add_b, add_sum;
    int          n_chk = 0;
    int          n_err = 0;

    fadd_accum_if #(.CNT_W(CNT_W)) bus ();

    fadd_accum #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum)
    );

    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [CNT_W-1:0] l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.len      = l;
    endtask

    initial begin
        logic [31:0] blk1 [4];
        blk1[0] = 32'd10; blk1[1] = -32'sd3; blk1[2] = 32'd7; blk1[3] = 32'd1;

        drive(1'b0, 32'h0, 8'd0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data",  bus.out_data,       32'd0);
        check_val("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        check_val("rst_add_a",     add_a,              32'd0);
        rst = 1'b0;

        // len=4 block: 10 + -3 + 7 + 1 = 15
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, blk1[i], 8'd4);
            tick();
            if (i == 0) check_val("b1_add_a_acc", add_a, 32'd10);
            if (i < 3)  check_val("b1_not_done", 32'(bus.out_valid), 32'd0);
        end
        drive(1'b0, 32'h0, 8'd4);
        check_val("b1_out_valid", 32'(bus.out_valid), 32'd1);
        check_val("b1_out_data",  bus.out_data,       32'd15);
        check_val("b1_out_ovf",   32'(bus.out_ovf),   32'd0);
        check_val("b1_in_ready",  32'(bus.in_ready),  32'd0);
        tick();
        check_val("b1_idle_valid", 32'(bus.out_valid), 32'd0);
        check_val("b1_idle_ready", 32'(bus.in_ready),  32'd1);

        // len=0 behaves as len=1
        drive(1'b1, 32'hFFFF_FFFE, 8'd0);
        tick();
        drive(1'b0, 32'h0, 8'd0);
        check_val("l0_out_valid", 32'(bus.out_valid), 32'd1);
        check_val("l0_out_data",  bus.out_data,       32'hFFFF_FFFE);
        tick();
        check_val("l0_idle", 32'(bus.out_valid), 32'd0);

        // positive overflow
        drive(1'b1, 32'h7FFF_FFFF, 8'd2);
        tick();
        drive(1'b1, 32'd1, 8'd2);
        tick();
        drive(1'b0, 32'h0, 8'd2);
        check_val("povf_valid", 32'(bus.out_valid), 32'd1);
        check_val("povf_ovf",   32'(bus.out_ovf),   32'd1);
`ifdef FADD_ACCUM_SAT_EN
        check_val("povf_data", bus.out_data, 32'h7FFF_FFFF);
`else
        check_val("povf_data", bus.out_data, 32'h8000_0000);
`endif
        tick();

        // negative overflow
        drive(1'b1, 32'h8000_0000, 8'd2);
        tick();
        drive(1'b1, 32'hFFFF_FFFF, 8'd2);
        tick();
        drive(1'b0, 32'h0, 8'd2);
        check_val("novf_ovf", 32'(bus.out_ovf), 32'd1);
`ifdef FADD_ACCUM_SAT_EN
        check_val("novf_data", bus.out_data, 32'h8000_0000);
`else
        check_val("novf_data", bus.out_data, 32'h7FFF_FFFF);
`endif
        tick();

        // len=3 with gaps, len change mid-block, backpressure: 100 - 30 + 5 = 75
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd100, 8'd3);
        tick();
        drive(1'b0, 32'd999, 8'd3);
        tick();
        tick();
        check_val("gap_no_done", 32'(bus.out_valid), 32'd0);
        check_val("gap_add_a",   add_a,              32'd100);
        drive(1'b1, -32'sd30, 8'd3);
        tick();
        drive(1'b0, 32'd0, 8'd3);
        tick();
        drive(1'b1, 32'd5, 8'd9);
        tick();
        drive(1'b1, 32'd1000, 8'd9);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check_val("bp_out_data",  bus.out_data,       32'd75);
            check_val("bp_out_ovf",   32'(bus.out_ovf),   32'd0);
            tick();
        end
        drive(1'b0, 32'h0, 8'd9);
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_release", 32'(bus.out_valid), 32'd0);

        // reset mid-block, then fresh block 5 + 6 = 11
        drive(1'b1, 32'd1, 8'd4);
        tick();
        drive(1'b1, 32'd2, 8'd4);
        tick();
        drive(1'b0, 32'h0, 8'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mrst_add_a",     add_a,              32'd0);
        check_val("mrst_out_data",  bus.out_data,       32'd0);
        check_val("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        drive(1'b1, 32'd5, 8'd2);
        tick();
        drive(1'b1, 32'd6, 8'd2);
        tick();
        drive(1'b0, 32'h0, 8'd2);
        check_val("post_rst_data",  bus.out_data,       32'd11);
        check_val("post_rst_valid", 32'(bus.out_valid), 32'd1);
        tick();

        // reset drops a pending result
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd42, 8'd1);
        tick();
        drive(1'b0, 32'h0, 8'd1);
        check_val("pend_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("pend_drop", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;

        // back-to-back len=1 blocks: in_ready 1,0,1,0
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(200 + i), 8'd1);
            check_val("b2b_in_ready", 32'(bus.in_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check_val("b2b_out_data", bus.out_data, 32'(200 + i - 1));
            tick();
        end
        drive(1'b0, 32'h0, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
